// File: rtl/crc5_pkg.sv
// Shared CRC-5 definitions for the serial crc5 generator and crc5_checker.
// Both ends call crc5_step so the two stay bit-exact.
package crc5_pkg;

  localparam int                CRC_W    = 5;
  localparam logic [CRC_W-1:0]  POLY     = 5'b00101;  // x^5 + x^2 + 1
  localparam logic [CRC_W-1:0]  CRC_INIT = 5'b00000;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC
  } state_t;

  // One MSB-first LFSR step: no reflection, no final XOR.
  function automatic logic [CRC_W-1:0] crc5_step(input logic [CRC_W-1:0] crc,
                                                 input logic             data_bit);
    logic fb;
    fb = crc[CRC_W-1] ^ data_bit;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

endpackage : crc5_pkg

// File: rtl/crc5_checker.sv
// Serial CRC-5 receiver/checker. A frame is DATA_W payload bits followed by
// the 5 transmitted CRC bits, MSB-first. The LFSR runs over payload plus
// received CRC; a zero residue marks the frame good.
module crc5_checker
  import crc5_pkg::*;
#(
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              start,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  crc_rx,
  output logic [CRC_W-1:0]  crc_calc,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic              crc_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;       // payload bits taken so far
  logic [2:0]          r_crc_cnt;   // CRC bits taken so far
  logic [CRC_W-1:0]    r_lfsr;
  logic [DATA_W-1:0]   r_data_out;
  logic [CRC_W-1:0]    r_crc_rx;
  logic [CRC_W-1:0]    r_crc_calc;
  logic                r_busy;
  logic                r_done;
  logic                r_crc_ok;
  logic                r_crc_err;

  // A start bit always reseeds the LFSR, whether from IDLE or as an abort.
  logic [CRC_W-1:0]    w_lfsr_seed;
  logic [CRC_W-1:0]    w_lfsr_next;
  logic [DATA_W-1:0]   w_data_shift;

  assign w_lfsr_seed  = start ? CRC_INIT : r_lfsr;
  assign w_lfsr_next  = crc5_step(w_lfsr_seed, data_in);
  // Shift written without a slice so DATA_W == 1 still elaborates.
  assign w_data_shift = (r_data_out << 1) | DATA_W'(data_in);

  // Frame FSM: payload capture, CRC capture, residue check, registered flags.
  // NOTE: every state register uses <= so all of them see the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_crc_cnt  <= '0;
      r_lfsr     <= CRC_INIT;
      r_data_out <= '0;
      r_crc_rx   <= '0;
      r_crc_calc <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_crc_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bit_valid) begin
        if (start) begin
          // New frame from IDLE, or abort-and-restart from DATA/CRC.
          r_lfsr     <= w_lfsr_next;
          r_data_out <= w_data_shift;
          r_crc_cnt  <= '0;
          r_busy     <= 1'b1;
          r_crc_ok   <= 1'b0;
          r_crc_err  <= 1'b0;
          if (DATA_W == 1) begin
            r_crc_calc <= w_lfsr_next;
            r_cnt      <= '0;
            r_state    <= CRC;
          end else begin
            r_cnt      <= CNT_W'(1);
            r_state    <= DATA;
          end
        end else begin
          case (r_state)
            DATA: begin
              r_lfsr     <= w_lfsr_next;
              r_data_out <= w_data_shift;
              if (r_cnt == CNT_W'(DATA_W - 1)) begin
                r_crc_calc <= w_lfsr_next;
                r_cnt      <= '0;
                r_state    <= CRC;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            CRC: begin
              r_lfsr   <= w_lfsr_next;
              r_crc_rx <= {r_crc_rx[CRC_W-2:0], data_in};
              if (r_crc_cnt == 3'(CRC_W - 1)) begin
                r_crc_cnt <= '0;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_crc_ok  <= (w_lfsr_next == '0);
                r_crc_err <= (w_lfsr_next != '0);
                r_state   <= IDLE;
              end else begin
                r_crc_cnt <= r_crc_cnt + 1'b1;
              end
            end
            default: ;  // IDLE: bits without start are ignored
          endcase
        end
      end
    end
  end

  assign data_out = r_data_out;
  assign crc_rx   = r_crc_rx;
  assign crc_calc = r_crc_calc;
  assign busy     = r_busy;
  assign done     = r_done;
  assign crc_ok   = r_crc_ok;
  assign crc_err  = r_crc_err;

endmodule : crc5_checker

// File: tb/tb_crc5_checker.sv
// Directed bench for crc5_checker with DATA_W = 4. Expected CRCs were worked
// by hand with x^5+x^2+1, init 0, MSB-first.
module tb_crc5_checker;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_valid;
  logic          start;
  logic          data_in;
  logic [DW-1:0] data_out;
  logic [4:0]    crc_rx;
  logic [4:0]    crc_calc;
  logic          busy;
  logic          done;
  logic          crc_ok;
  logic          crc_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int done_cnt = 0;
  int done_cycle = 0;

  crc5_checker #(.DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_valid(bit_valid),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .crc_rx   (crc_rx),
    .crc_calc (crc_calc),
    .busy     (busy),
    .done     (done),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err)
  );

  always #5 clk = ~clk;

  // Cycle counter and done-pulse monitor (sampled mid-cycle).
  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt   = done_cnt + 1;
      done_cycle = cycle;
    end
  end

  // Drive inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic s, input logic d);
    @(negedge clk);
    bit_valid = v;
    start     = s;
    data_in   = d;
    @(posedge clk);
    #1;
  endtask

  // Nine-bit frame; gapped mode inserts 1..3 idle cycles between bits.
  task automatic send_frame(input logic [DW-1:0] p, input logic [4:0] c, input bit gapped);
    logic [DW+4:0] bits;
    bits = {p, c};
    for (int i = DW + 4; i >= 0; i--) begin
      if (gapped && i != DW + 4) repeat ((i % 3) + 1) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, (i == DW + 4), bits[i]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bit_valid = 1'b0; start = 1'b0; data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({data_out, crc_rx, crc_calc} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0", data_out, crc_rx, crc_calc);
    end
    n_checks++;
    if ({busy, done, crc_ok, crc_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, crc_ok, crc_err});
    end
    @(negedge clk); reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic;
    int d0;
    d0 = done_cnt;
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done: got %b want 0", done); end
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({done, busy, crc_ok, crc_err} !== 4'b1010) begin
      n_fail++; $display("FAIL basic_flags: got %b want 1010", {done, busy, crc_ok, crc_err});
    end
    n_checks++;
    if ({data_out, crc_calc, crc_rx} !== {4'b0100, 5'b10100, 5'b10100}) begin
      n_fail++; $display("FAIL basic_data: got %b/%b/%b want 0100/10100/10100", data_out, crc_calc, crc_rx);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({done, crc_ok} !== 2'b01 || done_cnt !== d0 + 1) begin
      n_fail++; $display("FAIL basic_pulse: got done=%b ok=%b pulses=%0d want 0,1,%0d", done, crc_ok, done_cnt - d0, 1);
    end
  endtask

  task automatic test_gaps;
    int d0;
    d0 = done_cnt;
    send_frame(4'b1110, 5'b10011, 1'b1);
    n_checks++;
    if ({done, crc_ok, crc_err, crc_calc} !== {3'b110, 5'b10011}) begin
      n_fail++; $display("FAIL gaps_1110: got done=%b ok=%b err=%b calc=%b want 1,1,0,10011", done, crc_ok, crc_err, crc_calc);
    end
    drive(1'b0, 1'b0, 1'b0); drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_cnt !== d0 + 1 || done !== 1'b0) begin
      n_fail++; $display("FAIL gaps_single_pulse: got %0d pulses want 1", done_cnt - d0);
    end
    send_frame(4'b1111, 5'b10110, 1'b1);
    n_checks++;
    if ({done, crc_ok, crc_calc, data_out} !== {2'b11, 5'b10110, 4'b1111}) begin
      n_fail++; $display("FAIL gaps_1111: got done=%b ok=%b calc=%b data=%b want 1,1,10110,1111", done, crc_ok, crc_calc, data_out);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_crc;
    send_frame(4'b0100, 5'b10101, 1'b0);
    n_checks++;
    if ({done, crc_ok, crc_err} !== 3'b101) begin
      n_fail++; $display("FAIL bad_flags: got done/ok/err=%b want 101", {done, crc_ok, crc_err});
    end
    n_checks++;
    if ({crc_calc, crc_rx} !== {5'b10100, 5'b10101}) begin
      n_fail++; $display("FAIL bad_fields: got calc=%b rx=%b want 10100/10101", crc_calc, crc_rx);
    end
    drive(1'b0, 1'b0, 1'b0); drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({crc_ok, crc_err} !== 2'b01) begin
      n_fail++; $display("FAIL bad_hold: got ok/err=%b want 01", {crc_ok, crc_err});
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    send_frame(4'b0000, 5'b00000, 1'b0);
    n_checks++;
    if ({done, crc_ok} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_zero: got done/ok=%b want 11", {done, crc_ok});
    end
    drive(1'b1, 1'b1, 1'b1);  // start right after done; done monitor records frame 1
    c0 = done_cycle;
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_cycle - c0 !== 9) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 9", done_cycle - c0);
    end
    n_checks++;
    if ({crc_ok, data_out} !== {1'b1, 4'b1110}) begin
      n_fail++; $display("FAIL b2b_second: got ok=%b data=%b want 1/1110", crc_ok, data_out);
    end
  endtask

  task automatic test_abort;
    int d0;
    d0 = done_cnt;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    send_frame(4'b1110, 5'b10011, 1'b0);  // start lands on old payload bit 2
    n_checks++;
    if ({done, crc_ok, data_out, crc_calc} !== {2'b11, 4'b1110, 5'b10011}) begin
      n_fail++; $display("FAIL abort_result: got done=%b ok=%b data=%b calc=%b want 1,1,1110,10011", done, crc_ok, data_out, crc_calc);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_cnt !== d0 + 1) begin
      n_fail++; $display("FAIL abort_pulses: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    drive(1'b1, 1'b1, 1'b1); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({data_out, crc_rx, crc_calc, busy, done, crc_ok, crc_err} !== 18'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got %b/%b/%b flags=%b want all 0", data_out, crc_rx, crc_calc, {busy, done, crc_ok, crc_err});
    end
    @(negedge clk); reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got pulses=%0d busy=%b want 0,0", done_cnt - d0, busy);
    end
    send_frame(4'b0100, 5'b10100, 1'b0);
    n_checks++;
    if ({done, crc_ok, crc_rx} !== {2'b11, 5'b10100}) begin
      n_fail++; $display("FAIL reset_mid_recover: got done=%b ok=%b rx=%b want 1,1,10100", done, crc_ok, crc_rx);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bad_crc();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_crc5_checker

// File: doc/crc5_checker.md
# crc5_checker

Serial CRC-5 receiver and checker, the far-end counterpart of the team's serial `crc5` generator. It accepts a frame of `DATA_W` payload bits followed by the 5 transmitted CRC bits, all MSB-first. It recomputes the CRC over payload plus received CRC and flags the frame good (residue zero) or bad. It sits at the serial receive side, ahead of whatever consumes the recovered payload word.

## Interface
Parameters:
- `DATA_W`, default 11, payload length in bits (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bit_valid`  in  1  `data_in` carries a frame bit this cycle; low means hold all state.
- `start`  in  1  qualified by `bit_valid`; marks the current `data_in` as the first payload bit.
- `data_in`  in  1  serial bit, MSB-first.
- `data_out`  out  `DATA_W`  recovered payload; first received bit lands in `[DATA_W-1]`.
- `crc_rx`  out  5  received CRC field.
- `crc_calc`  out  5  CRC computed over the payload only.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse: frame complete, result outputs valid.
- `crc_ok`  out  1  last completed frame had zero residue.
- `crc_err`  out  1  last completed frame had non-zero residue.

## Operation
- CRC: polynomial x^5+x^2+1 (`POLY`=5'b00101), init 5'b00000, no reflection, no final XOR.
- Per-bit step: `fb = crc[4] ^ bit`; `crc_next = {crc[3:0],1'b0} ^ (fb ? POLY : 0)`.
- FSM states:
  - **IDLE**: when `bit_valid & start`: `lfsr = step(0, data_in)`, shift bit into `data_out`, `cnt = 1`, clear `crc_ok`/`crc_err`. Go to DATA, or go directly to CRC if `DATA_W == 1`. Bits with `start` low are ignored.
  - **DATA**: on each `bit_valid`: step LFSR, shift `data_out` left inserting `data_in`, `cnt++`. On the `DATA_W`th bit, latch `crc_calc` = stepped LFSR value, `cnt = 0`, go to CRC.
  - **CRC**: on each `bit_valid`: step LFSR, shift `crc_rx`. On the 5th bit: `done = 1`, `crc_ok = (lfsr_next == 0)`, `crc_err = ~crc_ok`, go to IDLE.
- `bit_valid & start` in DATA or CRC aborts the current frame. No `done` is issued. The frame restarts exactly as from IDLE, using this bit as payload bit 0.
- `crc_ok`/`crc_err` are mutually exclusive. They hold until the next `start` or reset.
- `bit_valid` low: FSM, counter, LFSR and shift registers hold. Gaps of any length are legal.

## Timing
- Reset values: `data_out`=0, `crc_rx`=0, `crc_calc`=0, `busy`=0, `done`=0, `crc_ok`=0, `crc_err`=0. State = IDLE, `cnt`=0, LFSR=0.
- Reset mid-frame discards the frame immediately (asynchronous); no `done`.
- All outputs are registered.
- `done`, `crc_ok` and `crc_err` become valid on the edge that samples the last CRC bit. `done` is high for exactly one cycle.
- `busy` rises on the edge sampling the start bit and falls with `done`.
- Minimum frame: `DATA_W+5` consecutive `bit_valid` cycles.
- A `start` in the cycle right after `done` is accepted (back-to-back frames).
- `cnt` width is `$clog2(DATA_W+1)`; it never exceeds `DATA_W`.

## Structure
- Package `crc5_pkg` holds `CRC_W`=5, `POLY`=5'b00101, `CRC_INIT`=5'b00000, the state enum `{IDLE, DATA, CRC}`, and function `crc5_step(crc, bit)`.
- The shared step function keeps the checker bit-exact with the `crc5` generator.
- Single module; no sub-module needed.

## Test plan
- `DATA_W`=4, payload 0,1,0,0 then CRC 1,0,1,0,0, continuous `bit_valid` -> `done` after 9th bit; `data_out`=4'b0100, `crc_calc`=`crc_rx`=5'b10100, `crc_ok`=1.
- `DATA_W`=4, payload 1,1,1,0 + CRC 10011 with `bit_valid` gaps of 1–3 cycles -> `crc_calc`=5'b10011, `crc_ok`=1, `done` a single pulse. Payload 1,1,1,1 + CRC 10110 -> `crc_ok`=1.
- `DATA_W`=4, payload 0100 + corrupted CRC 10101 -> `crc_err`=1, `crc_ok`=0, `crc_calc`=5'b10100, `crc_rx`=5'b10101.
- All-zero payload + CRC 00000 -> `crc_ok`=1. Immediately followed by a back-to-back frame 1110+10011 -> second `done` exactly 9 cycles later, `crc_ok`=1.
- Abort/reset: `start` reasserted at payload bit 2 -> no `done` for the first frame; the new frame completes correctly. Separately, `reset` pulsed during the CRC phase -> all outputs 0, `busy`=0, no `done`.
